img_capture: RTL and testbench

// - Receiving end of the erosion/dilation mesh. Samples the mesh's serial pixel output (one bit per clk, raster order).
// - Discards the mesh pipeline fill, packs bits into IMG_W-bit rows and hands each row to a consumer over a valid/ready port.
// - One frame per start pulse. Flags overflow when the consumer stalls longer than one row time.

---
 rtl/img_pkg.sv | 17 +
 rtl/img_capture_if.sv | 36 +++
 rtl/img_row_shifter.sv | 37 +++
 rtl/img_capture.sv | 154 +++++++++++++++
 tb/tb_img_capture.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/img_pkg.sv
// img_pkg: shared types and default geometry for the image capture block.
// Optional feature macro used by this slice: IMG_CAPTURE_PARITY_EN.
package img_pkg;

  typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, DRAIN} cap_state_t;

  // Defaults for the 4x4 erosion/dilation mesh
  localparam int IMG_W_DEF   = 8;
  localparam int IMG_H_DEF   = 8;
  localparam int LATENCY_DEF = 7;

  // Index width for a counter over n values; never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/img_capture_if.sv
// img_capture_if: row hand-off port (valid/ready) between img_capture and its consumer.
// With IMG_CAPTURE_PARITY_EN defined the row parity bit travels with the row.
interface img_capture_if
  import img_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) ();

  localparam int ROW_W = idx_w(IMG_H);

  logic             row_valid;
  logic             row_ready;
  logic [IMG_W-1:0] row_data;
  logic [ROW_W-1:0] row_idx;
`ifdef IMG_CAPTURE_PARITY_EN
  logic             row_parity;
`endif

  modport master (
    input  row_ready,
    output row_valid, row_data, row_idx
`ifdef IMG_CAPTURE_PARITY_EN
    , output row_parity
`endif
  );

  modport slave (
    output row_ready,
    input  row_valid, row_data, row_idx
`ifdef IMG_CAPTURE_PARITY_EN
    , input row_parity
`endif
  );

endinterface

// File: rtl/img_row_shifter.sv
// img_row_shifter: serial-to-parallel row assembly with a column counter.
// o_row is the complete row including the bit arriving this cycle, so the
// stored part only needs IMG_W-1 bits; o_row_full marks the last bit of a row.
module img_row_shifter
  import img_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [IMG_W-1:0] o_row,
  output logic             o_row_full
);

  localparam int              COL_W    = $clog2(IMG_W);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

  logic [IMG_W-2:0] r_sh;
  logic [COL_W-1:0] r_col;

  assign o_row      = {r_sh, i_bit};
  assign o_row_full = i_en && (r_col == COL_LAST);

  // Shift one pixel in per enabled cycle and count columns with explicit clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh  <= '0;
      r_col <= '0;
    end else if (i_en) begin
      r_sh  <= o_row[IMG_W-2:0];
      r_col <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
    end
  end

endmodule

// File: rtl/img_capture.sv
// img_capture: samples the mesh serial output, drops the pipeline fill,
// packs IMG_W-bit rows and hands them out over a valid/ready port.
// Optional macro IMG_CAPTURE_PARITY_EN adds a registered row parity bit.
module img_capture
  import img_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic img,
  output logic busy,
  output logic done,
  output logic overflow,
  img_capture_if.master row_if
);

  localparam int               ROW_W     = idx_w(IMG_H);
  localparam int               SKIP_W    = idx_w(LATENCY);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
  // SKIP is entered the cycle after start, so it lasts LATENCY-1 cycles
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

  cap_state_t       r_state;
  cap_state_t       w_next;
  logic [SKIP_W-1:0] r_skip;
  logic [ROW_W-1:0]  r_row;
  logic [IMG_W-1:0]  r_row_data;
  logic [ROW_W-1:0]  r_row_idx;
  logic              r_row_valid;
  logic              r_done;
  logic              r_overflow;
  logic              w_shift_en;
  logic              w_row_full;
  logic [IMG_W-1:0]  w_row;
  logic              w_hs;
  logic              w_start_ok;
  logic              w_last_row;

  assign w_start_ok = (r_state == IDLE) && start;
  assign w_hs       = r_row_valid && row_if.row_ready;
  assign w_last_row = w_row_full && (r_row == ROW_LAST);

  img_row_shifter #(.IMG_W(IMG_W)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_shift_en),
    .i_bit     (img),
    .o_row     (w_row),
    .o_row_full(w_row_full)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; start outside IDLE is ignored
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (LATENCY <= 1) ? CAPTURE : SKIP;
      SKIP:    if (r_skip == SKIP_LAST) w_next = CAPTURE;
      CAPTURE: if (w_last_row) w_next = DRAIN;
      DRAIN:   if (w_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State outputs; with zero latency the start-cycle pixel is already valid
  always_comb begin
    w_shift_en = 1'b0;
    busy       = 1'b0;
    case (r_state)
      IDLE:    w_shift_en = (LATENCY == 0) && start;
      SKIP:    busy = 1'b1;
      CAPTURE: begin
        busy       = 1'b1;
        w_shift_en = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      default: ;
    endcase
  end

  // Skip and row counters, restarted by an accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skip <= '0;
      r_row  <= '0;
    end else begin
      if (w_start_ok)
        r_skip <= '0;
      else if (r_state == SKIP)
        r_skip <= (r_skip == SKIP_LAST) ? '0 : r_skip + 1'b1;
      if (w_start_ok)
        r_row <= '0;
      else if (w_row_full)
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
    end
  end

  // Single-entry holding register; a new row always wins over an unread one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_data  <= '0;
      r_row_idx   <= '0;
      r_row_valid <= 1'b0;
    end else if (w_row_full) begin
      r_row_data  <= w_row;
      r_row_idx   <= r_row;
      r_row_valid <= 1'b1;
    end else if (w_hs) begin
      r_row_valid <= 1'b0;
    end
  end

  // Sticky overflow (cleared by start) and the done pulse after the last handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_start_ok)
        r_overflow <= 1'b0;
      else if (w_row_full && r_row_valid && !row_if.row_ready)
        r_overflow <= 1'b1;
      r_done <= (r_state == DRAIN) && w_hs;
    end
  end

`ifdef IMG_CAPTURE_PARITY_EN
  logic r_parity;

  // Parity registered with the row so it is valid exactly when row_valid is
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_parity <= 1'b0;
    else if (w_row_full) r_parity <= ^w_row;
  end

  assign row_if.row_parity = r_parity;
`endif

  assign row_if.row_valid = r_row_valid;
  assign row_if.row_data  = r_row_data;
  assign row_if.row_idx   = r_row_idx;
  assign done             = r_done;
  assign overflow         = r_overflow;

endmodule

// File: tb/tb_img_capture.sv
// tb_img_capture: directed frames for img_capture; the driver pushes expected
// rows and done timing into queues, a negedge monitor pops and compares.
module tb_img_capture;
  import img_pkg::*;

  localparam int W = 8;
  localparam int H = 8;
  localparam int L = 7;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] idx;
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic img = 1'b0;
  logic busy, done, overflow;

  img_capture_if #(.IMG_W(W), .IMG_H(H)) rif ();

  img_capture #(.IMG_W(W), .IMG_H(H), .LATENCY(L)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .img     (img),
    .busy    (busy),
    .done    (done),
    .overflow(overflow),
    .row_if  (rif.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  row_t       exp_q[$];
  int         done_q[$];
  int         s_cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] frm[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  // Monitor: compare every handshaken row and every done pulse
  always @(negedge clk) begin
    row_t e;
    if (!rst) begin
      if (rif.row_valid && rif.row_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_row: got %0h idx %0d, required no row", rif.row_data, rif.row_idx);
        end else begin
          e = exp_q.pop_front();
          chk("row_data", {24'd0, rif.row_data}, {24'd0, e.d});
          chk("row_idx", {29'd0, rif.row_idx}, {29'd0, e.idx});
`ifdef IMG_CAPTURE_PARITY_EN
          chk("row_parity", {31'd0, rif.row_parity}, {31'd0, ^e.d});
`endif
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc + 1 - s_cyc);
        end else begin
          chk("done_cycle", cyc + 1 - s_cyc, done_q.pop_front());
        end
      end
    end
  end

  // One frame: skip window filled with skipv, then frm[] MSB first.
  // Ready is low for bit indices stall_lo..stall_hi; rst_k >= 0 resets mid-frame;
  // extra_k >= 0 pulses start at that bit and again while draining.
  task automatic run_frame(input logic skipv, input int stall_lo, input int stall_hi,
                           input int rst_k, input int extra_k, input logic exp_ovf);
    int t;
    @(posedge clk); #1;
    start = 1'b1;
    img   = skipv;
    s_cyc = cyc + 1;
    for (int r = 0; r < H; r++) begin
      if ((stall_lo >= 0) && (r == 2)) continue;
      if ((rst_k >= 0) && (r >= 4)) continue;
      exp_q.push_back('{d: frm[r], idx: 3'(r)});
    end
    if (rst_k < 0) done_q.push_back(L + W * H + 1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("overflow_cleared", {31'd0, overflow}, 32'd0);
    for (int j = 1; j < L; j++) begin
      img = skipv;
      @(posedge clk); #1;
    end
    for (int k = 0; k < W * H; k++) begin
      img           = frm[k / W][W - 1 - (k % W)];
      rif.row_ready = !((k >= stall_lo) && (k <= stall_hi));
      start         = (k == extra_k);
      if (k == rst_k) begin
        rst = 1'b1;
        #4;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_row_valid", {31'd0, rif.row_valid}, 32'd0);
        chk("rst_row_data", {24'd0, rif.row_data}, 32'd0);
        chk("rst_row_idx", {29'd0, rif.row_idx}, 32'd0);
        @(posedge clk); #1;
        rst   = 1'b0;
        img   = 1'b0;
        start = 1'b0;
        rif.row_ready = 1'b1;
        repeat (90) @(posedge clk);
        #1;
        chk("rst_idle_busy", {31'd0, busy}, 32'd0);
        chk("rst_rows_drained", exp_q.size(), 32'd0);
        return;
      end
      @(posedge clk); #1;
    end
    img           = 1'b0;
    rif.row_ready = 1'b1;
    start         = (extra_k >= 0);
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while ((done_q.size() != 0) && (t < 200)) begin
      @(posedge clk); #1;
      t++;
    end
    chk("done_seen", done_q.size(), 32'd0);
    chk("rows_drained", exp_q.size(), 32'd0);
    chk("overflow_end", {31'd0, overflow}, {31'd0, exp_ovf});
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rif.row_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    chk("reset_row_valid", {31'd0, rif.row_valid}, 32'd0);
    chk("reset_row_data", {24'd0, rif.row_data}, 32'd0);
    chk("reset_row_idx", {29'd0, rif.row_idx}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Plain frame of 0xA5 rows, always-ready consumer
    for (int r = 0; r < H; r++) frm[r] = 8'hA5;
    run_frame(1'b0, -1, -1, -1, -1, 1'b0);

    // Ones in the skip window must never reach a row
    for (int r = 0; r < H; r++) frm[r] = 8'h00;
    run_frame(1'b1, -1, -1, -1, -1, 1'b0);

    // Consumer stalls 12 cycles after row 2 loads: row 3 replaces row 2
    for (int r = 0; r < H; r++) frm[r] = 8'(8'h11 * (r + 1));
    run_frame(1'b0, 24, 35, -1, -1, 1'b1);

    // Reset in the middle of row 4 (also checks start cleared overflow)
    for (int r = 0; r < H; r++) frm[r] = (r % 2 == 0) ? 8'hC3 : 8'h3C;
    run_frame(1'b0, -1, -1, 34, -1, 1'b0);

    // Clean frame after reset, with start pulses while busy
    for (int r = 0; r < H; r++) frm[r] = 8'(8'h81 ^ (r << 2));
    run_frame(1'b0, -1, -1, -1, 10, 1'b0);

    // Odd-parity rows
    for (int r = 0; r < H; r++) frm[r] = 8'hA4;
    run_frame(1'b0, -1, -1, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
